trig_capture_buffer: RTL and testbench
======================================

# trig_capture_buffer

Parametrised in-fabric logic-analyzer core for on-board debug of the frame-buffer/DDR datapath. It samples a probe bus every clock into a circular block-RAM buffer and compares each sample against a masked value with level or rising-edge trigger modes. After a trigger it keeps a programmable number of pre-trigger samples, freezes the capture, and exposes the buffer through a simple registered read port. It runs standalone, or feeds firmware or a UART readout, with no vendor debug cores.

## Interface
- DATA_WIDTH, 35, probe bus width (≥1)
- DEPTH_LOG2, 10, buffer depth = 2^DEPTH_LOG2 samples (≥2)
- PRE_TRIG, 256, samples retained before the trigger sample; 0 ≤ PRE_TRIG < 2^DEPTH_LOG2
- CLK  in  1  sole clock; all logic rising-edge
- RESET  in  1  asynchronous, active-high reset
- TRIG0  in  DATA_WIDTH  probe data, sampled every cycle
- ARM  in  1  single-cycle start/restart request
- TRIG_MASK  in  DATA_WIDTH  compare mask; a bit at 1 participates in the compare
- TRIG_VALUE  in  DATA_WIDTH  compare value
- TRIG_MODE  in  1  0 = level match, 1 = rising edge of match
- RD_EN  in  1  read request
- RD_ADDR  in  DEPTH_LOG2  read index relative to oldest retained sample
- RD_DATA  out  DATA_WIDTH  read data, registered
- RD_VALID  out  1  pulses one cycle after RD_EN
- STATE  out  3  IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4
- DONE  out  1  high while STATE=DONE
- TRIG_ADDR  out  DEPTH_LOG2  physical buffer address of the trigger sample

## Operation
- Input stage: TRIG0 is registered into s_data every cycle. match = ((s_data ^ TRIG_VALUE) & TRIG_MASK) == 0. prev_match is the registered match and updates every cycle in all states.
- hit = match when TRIG_MODE=0; hit = match & ~prev_match when TRIG_MODE=1. A constant matching value does not produce an edge hit.
- Write pointer wr_ptr (DEPTH_LOG2 bits) wraps modulo 2^DEPTH_LOG2. In PRE, WAIT and POST, s_data is written to wr_ptr every cycle and wr_ptr increments.
- IDLE: no writes. ARM → PRE, with wr_ptr=0 and pre_cnt=0.
- PRE: pre_cnt counts writes. Hits are ignored. On the cycle the PRE_TRIG-th sample is written → WAIT. If PRE_TRIG=0, ARM goes directly to WAIT.
- WAIT: writes continue and wrap. On hit, the current sample is written at wr_ptr, TRIG_ADDR ← wr_ptr, post_cnt ← 0, → POST. If the hit is the last-written sample's cycle of PRE, it is ignored.
- POST: writes exactly 2^DEPTH_LOG2 − PRE_TRIG − 1 further samples, then → DONE. If that count is 0, the trigger cycle goes straight to DONE.
- DONE: no writes; the buffer is frozen. Exit only by ARM (→ PRE) or RESET.
- ARM in any state restarts the capture: wr_ptr=0, pre_cnt=0, → PRE (or WAIT if PRE_TRIG=0), and DONE deasserts. ARM takes priority over a simultaneous hit or POST completion.
- Readout: phys = (TRIG_ADDR − PRE_TRIG + RD_ADDR) mod 2^DEPTH_LOG2. RD_ADDR=PRE_TRIG returns the trigger sample; RD_ADDR=2^DEPTH_LOG2−1 returns the newest sample.
- Reads are valid only in DONE. RD_EN in any other state still pulses RD_VALID, with RD_DATA=0.
- Memory: simple dual-port RAM inferred as block RAM, write port and registered read port on CLK.

## Timing
- Reset values: STATE=0 (IDLE), DONE=0, TRIG_ADDR=0, RD_DATA=0, RD_VALID=0, wr_ptr=0, counters=0, s_data=0, prev_match=0.
- Sample latency: the TRIG0 value at edge n is written at edge n+1.
- The first written sample is the TRIG0 value present in the cycle ARM is high.
- Trigger-to-TRIG_ADDR: TRIG_ADDR and STATE=POST update at the edge that writes the trigger sample.
- DONE asserts the cycle after the last POST write.
- Read latency: RD_EN/RD_ADDR at edge n gives RD_DATA/RD_VALID at edge n+1. Back-to-back reads run at one per cycle.
- RESET asserted mid-capture forces IDLE immediately, asynchronously. Buffer contents are undefined afterwards.

## Test plan
Bench: DATA_WIDTH=8, DEPTH_LOG2=4, PRE_TRIG=4; TRIG0 = free-running 8-bit counter starting at 0x00 on the ARM cycle.

- Level trigger: MASK=0xFF, VALUE=0x20, MODE=0, ARM. Required: DONE rises; RD_ADDR 0..15 return 0x1C..0x2B; RD_ADDR 4 returns 0x20; TRIG_ADDR=0x0.
- Pre-trigger blanking: MASK=0x0F, VALUE=0x02. Required: 0x02 (in PRE) is ignored; the trigger fires on 0x12; RD_ADDR 0 returns 0x0E, RD_ADDR 4 returns 0x12, RD_ADDR 15 returns 0x1D.
- Edge mode: TRIG0 held at 0x55, MASK=0xFF, VALUE=0x55, MODE=1, ARM. Required: STATE stays 2 for 100 cycles. Then drive 0x00 for one cycle and 0x55 again. Required: trigger on that 0x55, and RD_ADDR 4 reads 0x55 with RD_ADDR 3 reading 0x00.
- Re-arm: ARM during POST. Required: STATE=1 the next cycle, DONE=0; the subsequent capture matches the level-trigger expectations relative to the new ARM.
- Reset and idle reads: assert RESET during WAIT. Required: all outputs return to reset values immediately. Then RD_EN with RD_ADDR=5 in IDLE. Required: RD_VALID=1 one cycle later, RD_DATA=0x00.

Source files
------------

// File: rtl/trig_capture_buffer.sv
// In-fabric logic-analyzer core: samples a probe bus into a circular block RAM,
// triggers on a masked level or rising-edge match, and freezes with pre/post context.
module trig_capture_buffer #(
    parameter int DATA_WIDTH = 35,
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] trig0,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  trig_mode,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [2:0]            state,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_addr
);

    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int POST_N    = DEPTH - PRE_TRIG - 1;
    localparam int PRE_LAST  = (PRE_TRIG > 0) ? PRE_TRIG - 1 : 0;
    localparam int POST_LAST = (POST_N > 0) ? POST_N - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   pre_cnt_q, pre_cnt_d;
    logic [DEPTH_LOG2-1:0]   post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2-1:0]   trig_addr_q, trig_addr_d;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    prev_match;
    logic                    match;
    logic                    hit;
    logic                    we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rd;
    logic                    rd_ok;
    logic [DEPTH_LOG2-1:0]   rd_phys;

    assign match = ((s_data ^ trig_value) & trig_mask) == '0;
    assign hit   = trig_mode ? (match & ~prev_match) : match;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        we          = 1'b0;
        if (arm) begin
            // Restart wins over any trigger or completion in the same cycle.
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            state_d    = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
        end else begin
            case (state_q)
                S_PRE: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(1);
                    pre_cnt_d = pre_cnt_q + DEPTH_LOG2'(1);
                    if (pre_cnt_q == DEPTH_LOG2'(PRE_LAST))
                        state_d = S_WAIT;
                end
                S_WAIT: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = '0;
                        state_d     = (POST_N == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(1);
                    post_cnt_d = post_cnt_q + DEPTH_LOG2'(1);
                    if (post_cnt_q == DEPTH_LOG2'(POST_LAST))
                        state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            s_data      <= '0;
            prev_match  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_ok       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            s_data      <= trig0;
            prev_match  <= match;
            rd_valid    <= rd_en;
            if (rd_en)
                rd_ok <= (state_q == S_DONE);
        end
    end

    // Read port: rd_en is a request with no back-pressure; rd_valid follows it
    // by exactly one cycle. Data outside DONE is forced to zero via rd_ok.
    assign rd_phys = trig_addr_q - DEPTH_LOG2'(PRE_TRIG) + rd_addr;

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr_q] <= s_data;
        if (rd_en)
            mem_rd <= mem[rd_phys];
    end

    assign rd_data   = rd_ok ? mem_rd : '0;
    assign state     = state_q;
    assign done      = (state_q == S_DONE);
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_trig_capture_buffer.sv
// Directed bench for trig_capture_buffer: table of level-trigger captures plus
// hand-written edge-mode, re-arm and reset sequences.
module tb_trig_capture_buffer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] trig0;
    logic          arm;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic          trig_mode;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    state;
    logic          done;
    logic [AW-1:0] trig_addr;

    int n_cmp  = 0;
    int n_fail = 0;
    logic cnt_mode;

    trig_capture_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .PRE_TRIG(4)) dut (
        .clk(clk), .reset(reset), .trig0(trig0), .arm(arm),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_mode(trig_mode),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .state(state), .done(done), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] mask;
        logic [DW-1:0] value;
        logic [AW-1:0] exp_taddr;
        logic [DW-1:0] exp_first;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge, outputs read there too.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_mode)
            trig0 = trig0 + 8'd1;
    endtask

    task automatic do_arm();
        if (cnt_mode)
            trig0 = 8'h00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_state%0d_timeout", s), {29'd0, state}, {29'd0, s});
    endtask

    task automatic check_buffer(input string tag, input logic [DW-1:0] first);
        logic [DW-1:0] exp;
        for (int r = 0; r < (1 << AW); r++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(r);
            tick();
            exp = first + DW'(r);
            chk($sformatf("%s_rd_data[%0d]", tag, r), {24'd0, rd_data}, {24'd0, exp});
            chk($sformatf("%s_rd_valid[%0d]", tag, r), {31'd0, rd_valid}, 32'd1);
        end
        rd_en = 1'b0;
    endtask

    task automatic read_one(input logic [AW-1:0] a, output logic [DW-1:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        d     = rd_data;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int bad;

        vecs[0] = '{mask: 8'hFF, value: 8'h20, exp_taddr: 4'h0, exp_first: 8'h1C};
        vecs[1] = '{mask: 8'h0F, value: 8'h02, exp_taddr: 4'h2, exp_first: 8'h0E};
        vecs[2] = '{mask: 8'h00, value: 8'h00, exp_taddr: 4'h4, exp_first: 8'h00};
        vecs[3] = '{mask: 8'hFF, value: 8'h07, exp_taddr: 4'h7, exp_first: 8'h03};
        vecs[4] = '{mask: 8'hFF, value: 8'h03, exp_taddr: 4'h3, exp_first: 8'hFF};

        reset = 1'b1; trig0 = '0; arm = 1'b0; trig_mask = '0; trig_value = '0;
        trig_mode = 1'b0; rd_en = 1'b0; rd_addr = '0; cnt_mode = 1'b1;
        #12;
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_trig_addr", {28'd0, trig_addr}, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();

        // Re-arm during POST restarts the capture from the new ARM.
        trig_mask = 8'hFF; trig_value = 8'h20; trig_mode = 1'b0;
        do_arm();
        wait_state(3'd3, 200);
        do_arm();
        chk("rearm_state", {29'd0, state}, 32'd1);
        chk("rearm_done", {31'd0, done}, 32'd0);
        wait_state(3'd4, 200);
        chk("rearm_trig_addr", {28'd0, trig_addr}, 32'd0);
        check_buffer("rearm", 8'h1C);

        for (int i = 0; i < 5; i++) begin
            trig_mask  = vecs[i].mask;
            trig_value = vecs[i].value;
            trig_mode  = 1'b0;
            do_arm();
            wait_state(3'd4, 600);
            chk($sformatf("vec%0d_done", i), {31'd0, done}, 32'd1);
            chk($sformatf("vec%0d_trig_addr", i), {28'd0, trig_addr}, {28'd0, vecs[i].exp_taddr});
            check_buffer($sformatf("vec%0d", i), vecs[i].exp_first);
        end

        // Reset mid-capture clears every output without waiting for a clock edge.
        do_arm();
        wait_state(3'd2, 50);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trig_addr", {28'd0, trig_addr}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        read_one(4'd5, d);
        chk("idle_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("idle_rd_data", {24'd0, d}, 32'd0);
        tick();
        chk("idle_rd_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Edge mode: a held match never fires; a 0 -> match transition does.
        cnt_mode = 1'b0;
        trig0 = 8'h55; trig_mask = 8'hFF; trig_value = 8'h55; trig_mode = 1'b1;
        repeat (3) tick();
        do_arm();
        repeat (5) tick();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (state !== 3'd2)
                bad++;
            tick();
        end
        chk("edge_hold_not_wait_count", bad, 0);
        trig0 = 8'h00;
        tick();
        trig0 = 8'h55;
        wait_state(3'd4, 100);
        read_one(4'd2, d);
        chk("edge_rd2", {24'd0, d}, 32'h55);
        read_one(4'd3, d);
        chk("edge_rd3", {24'd0, d}, 32'h00);
        read_one(4'd4, d);
        chk("edge_rd4", {24'd0, d}, 32'h55);
        read_one(4'd15, d);
        chk("edge_rd15", {24'd0, d}, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
